// File: rtl/vga_fb_scheduler.sv
// Shares one single-port framebuffer RAM between VGA pixel fetch and a game writer.
// Display reads own every 4th visible column; writes drain through a 1-entry buffer.
module vga_fb_scheduler #(
    parameter int unsigned H_ACTIVE     = 640,
    parameter int unsigned V_ACTIVE     = 480,
    parameter int unsigned H_SYNC_START = 656,
    parameter int unsigned H_SYNC_END   = 751,
    parameter int unsigned V_SYNC_START = 490,
    parameter int unsigned V_SYNC_END   = 491,
    parameter int unsigned PIX_W        = 4,
    parameter int unsigned ADDR_W       = 17
) (
    input  logic                 CLK25MHZ,
    input  logic                 RST,
    input  logic [15:0]          H_count_value,
    input  logic [15:0]          V_count_value,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic                 mem_we,
    output logic [4*PIX_W-1:0]   mem_wdata,
    input  logic [4*PIX_W-1:0]   mem_rdata,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic [4*PIX_W-1:0]   wr_data,
    output logic [PIX_W-1:0]     pixel,
    output logic                 hsync,
    output logic                 vsync,
    output logic                 video_on,
    output logic                 frame_start
);
    localparam int unsigned WORD_W = 4 * PIX_W;

    logic              in_h_c, in_v_c, vis_c, disp_slot_c, drain_c, hs_c, vs_c, fs_c;
    logic [ADDR_W-1:0] dcnt;
    logic              buf_full;
    logic [ADDR_W-1:0] buf_addr;
    logic [WORD_W-1:0] buf_data;
    logic              rd_pend;
    logic [WORD_W-1:0] shreg;
    logic [PIX_W-1:0]  pix_c;
    logic              vis_d1, hs_d1, vs_d1, fs_d1;

    // Raster decode of the incoming counter position
    always_comb begin
        in_h_c      = H_count_value < 16'(H_ACTIVE);
        in_v_c      = V_count_value < 16'(V_ACTIVE);
        vis_c       = in_h_c && in_v_c;
        disp_slot_c = vis_c && (H_count_value[1:0] == 2'b00);
        hs_c        = !((H_count_value >= 16'(H_SYNC_START)) && (H_count_value <= 16'(H_SYNC_END)));
        vs_c        = !((V_count_value >= 16'(V_SYNC_START)) && (V_count_value <= 16'(V_SYNC_END)));
        fs_c        = (H_count_value == 16'd0) && (V_count_value == 16'd0);
    end

    // RAM port mux: display slot wins, otherwise a buffered write may drain
    always_comb begin
        drain_c   = !disp_slot_c && buf_full;
        mem_addr  = disp_slot_c ? dcnt : buf_addr;
        mem_we    = drain_c;
        mem_wdata = buf_data;
        wr_ready  = !buf_full || drain_c;
    end

    // Word address counter, rewound throughout vertical blanking
    always_ff @(posedge CLK25MHZ or posedge RST) begin
        if (RST) begin
            dcnt <= '0;
        end else if (!in_v_c) begin
            dcnt <= '0;
        end else if (disp_slot_c) begin
            dcnt <= dcnt + ADDR_W'(1);
        end
    end

    // One-entry write buffer; accept and drain in the same cycle keeps it full
    always_ff @(posedge CLK25MHZ or posedge RST) begin
        if (RST) begin
            buf_full <= 1'b0;
            buf_addr <= '0;
            buf_data <= '0;
        end else if (wr_valid && wr_ready) begin
            buf_full <= 1'b1;
            buf_addr <= wr_addr;
            buf_data <= wr_data;
        end else if (drain_c) begin
            buf_full <= 1'b0;
        end
    end

    always_comb pix_c = rd_pend ? mem_rdata[PIX_W-1:0] : shreg[PIX_W-1:0];

    // Pixel unpack and 2-cycle sync alignment so all outputs refer to column H-2
    always_ff @(posedge CLK25MHZ or posedge RST) begin
        if (RST) begin
            rd_pend     <= 1'b0;
            shreg       <= '0;
            pixel       <= '0;
            vis_d1      <= 1'b0;
            hs_d1       <= 1'b1;
            vs_d1       <= 1'b1;
            fs_d1       <= 1'b0;
            video_on    <= 1'b0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            rd_pend     <= disp_slot_c;
            shreg       <= rd_pend ? (mem_rdata >> PIX_W) : (shreg >> PIX_W);
            pixel       <= vis_d1 ? pix_c : '0;
            vis_d1      <= vis_c;
            hs_d1       <= hs_c;
            vs_d1       <= vs_c;
            fs_d1       <= fs_c;
            video_on    <= vis_d1;
            hsync       <= hs_d1;
            vsync       <= vs_d1;
            frame_start <= fs_d1;
        end
    end
endmodule

// File: tb/tb_vga_fb_scheduler.sv
// Bench for vga_fb_scheduler: bench-owned RAM, raster-level reference model,
// writer scoreboard, a sync/visibility vector table and hand-written corner sequences.
module tb_vga_fb_scheduler;
    localparam int HA = 640;
    localparam int VA = 480;
    localparam int WPL = HA / 4;

    logic        CLK25MHZ = 1'b0;
    logic        RST;
    logic [15:0] H_count_value, V_count_value;
    logic [16:0] mem_addr;
    logic        mem_we;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = 16'd0;
    logic        wr_valid, wr_ready;
    logic [16:0] wr_addr;
    logic [15:0] wr_data;
    logic [3:0]  pixel;
    logic        hsync, vsync, video_on, frame_start;

    vga_fb_scheduler dut (
        .CLK25MHZ(CLK25MHZ), .RST(RST),
        .H_count_value(H_count_value), .V_count_value(V_count_value),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .pixel(pixel), .hsync(hsync), .vsync(vsync), .video_on(video_on),
        .frame_start(frame_start)
    );

    initial forever #20 CLK25MHZ = ~CLK25MHZ;

    typedef struct packed {
        logic [15:0] h;
        logic [15:0] v;
        logic        hs;
        logic        vs;
        logic        von;
        logic        fs;
    } vec_t;

    typedef struct packed {
        logic [16:0] a;
        logic [15:0] d;
    } wr_t;

    typedef struct packed {
        logic [15:0] h;
        logic [16:0] a;
        logic [15:0] d;
    } wlog_t;

    vec_t  tbl [0:12];
    bit [15:0] ram [0:131071];
    wr_t   wr_todo[$];
    wr_t   sb[$];
    wlog_t wlog[$];
    int    alog[$];
    int    n_chk = 0;
    int    n_fail = 0;
    int    acc_cnt = 0;
    bit    pix_chk = 1'b0;
    int    h1h, h1v, h2h, h2v;
    bit    h1ok = 1'b0;
    bit    h2ok = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at H=%0d V=%0d t=%0t",
                     nm, act, exp, H_count_value, V_count_value, $time);
        end
    endtask

    task automatic step(input int h, input int v);
        @(posedge CLK25MHZ);
        #1;
        H_count_value = 16'(h);
        V_count_value = 16'(v);
        @(negedge CLK25MHZ);
    endtask

    task automatic run_line(input int v, input int h0, input int h1);
        for (int h = h0; h <= h1; h++) step(h, v);
    endtask

    // Synchronous-read RAM owned by the bench
    initial forever begin
        @(posedge CLK25MHZ);
        if (mem_we) ram[mem_addr] = mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    // Raster position history: outputs in a cycle describe the position two cycles back
    initial forever begin
        @(posedge CLK25MHZ or posedge RST);
        if (RST) begin
            h1ok = 1'b0;
            h2ok = 1'b0;
        end else begin
            h2h = h1h; h2v = h1v; h2ok = h1ok;
            h1h = int'(H_count_value); h1v = int'(V_count_value); h1ok = 1'b1;
        end
    end

    // Writer: presents queued words, holding them until accepted
    initial begin : writer
        int popped;
        popped = 0;
        forever begin
            @(posedge CLK25MHZ);
            #2;
            if (popped < acc_cnt) begin
                popped++;
                void'(wr_todo.pop_front());
                wr_valid = 1'b0;
            end
            if (RST) begin
                wr_valid = 1'b0;
            end else if (!wr_valid && wr_todo.size() > 0) begin
                wr_valid = 1'b1;
                wr_addr  = wr_todo[0].a;
                wr_data  = wr_todo[0].d;
            end
        end
    end

    // Reference model and scoreboard, evaluated mid-cycle
    initial begin : monitor
        bit ds, hs_e, vs_e, vis_e, fs_e;
        int occ, h, v, a;
        logic [15:0] w;
        wlog_t e;
        wr_t n;
        forever begin
            @(negedge CLK25MHZ);
            if (RST) sb.delete();
            h   = int'(H_count_value);
            v   = int'(V_count_value);
            ds  = (v < VA) && (h < HA) && (h % 4 == 0);
            occ = sb.size();
            chk("mem_we", 32'(mem_we), 32'(!ds && occ > 0));
            chk("wr_ready", 32'(wr_ready), 32'(!(ds && occ > 0)));
            if (ds && pix_chk) chk("rd_addr", 32'(mem_addr), 32'(v * WPL + h / 4));
            if (mem_we) begin
                e.h = H_count_value; e.a = mem_addr; e.d = mem_wdata;
                wlog.push_back(e);
                if (occ > 0) begin
                    chk("wr_addr", 32'(mem_addr), 32'(sb[0].a));
                    chk("wr_data", 32'(mem_wdata), 32'(sb[0].d));
                    void'(sb.pop_front());
                end
            end
            if (!RST && wr_valid && wr_ready) begin
                n.a = wr_addr; n.d = wr_data;
                sb.push_back(n);
                alog.push_back(h);
                acc_cnt++;
            end
            hs_e  = !(h2ok && h2h >= 656 && h2h <= 751);
            vs_e  = !(h2ok && h2v >= 490 && h2v <= 491);
            vis_e = h2ok && h2h < HA && h2v < VA;
            fs_e  = h2ok && h2h == 0 && h2v == 0;
            chk("hsync", 32'(hsync), 32'(hs_e));
            chk("vsync", 32'(vsync), 32'(vs_e));
            chk("video_on", 32'(video_on), 32'(vis_e));
            chk("frame_start", 32'(frame_start), 32'(fs_e));
            if (!vis_e) begin
                chk("pixel_blank", 32'(pixel), 32'd0);
            end else if (pix_chk) begin
                a = h2v * WPL + h2h / 4;
                w = ram[a] >> (4 * (h2h % 4));
                chk("pixel", 32'(pixel), 32'(w[3:0]));
            end
        end
    end

    initial begin : main
        wr_t w;
        int  cnt;
        RST = 1'b0; H_count_value = 16'd0; V_count_value = 16'd0;
        wr_valid = 1'b0; wr_addr = 17'd0; wr_data = 16'd0;
        tbl[0]  = '{16'd0,   16'd0,   1'b1, 1'b1, 1'b1, 1'b1};
        tbl[1]  = '{16'd639, 16'd479, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[2]  = '{16'd640, 16'd0,   1'b1, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{16'd655, 16'd0,   1'b1, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{16'd656, 16'd0,   1'b0, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{16'd751, 16'd5,   1'b0, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{16'd752, 16'd5,   1'b1, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{16'd100, 16'd489, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{16'd100, 16'd490, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{16'd700, 16'd491, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{16'd0,   16'd492, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{16'd900, 16'd600, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[12] = '{16'd4,   16'd480, 1'b1, 1'b1, 1'b0, 1'b0};

        #2 RST = 1'b1;
        repeat (3) @(negedge CLK25MHZ);
        chk("rst_pixel", 32'(pixel), 32'd0);
        chk("rst_hsync", 32'(hsync), 32'd1);
        chk("rst_vsync", 32'(vsync), 32'd1);
        chk("rst_video_on", 32'(video_on), 32'd0);
        chk("rst_wr_ready", 32'(wr_ready), 32'd1);
        #5 RST = 1'b0;
        step(0, 0);
        chk("post_rst_ready", 32'(wr_ready), 32'd1);
        chk("post_rst_we", 32'(mem_we), 32'd0);

        // Sync / visibility vectors: hold each position so the 2-cycle delay settles
        for (int i = 0; i < 13; i++) begin
            repeat (3) step(int'(tbl[i].h), int'(tbl[i].v));
            chk("tbl_hsync", 32'(hsync), 32'(tbl[i].hs));
            chk("tbl_vsync", 32'(vsync), 32'(tbl[i].vs));
            chk("tbl_video_on", 32'(video_on), 32'(tbl[i].von));
            chk("tbl_frame_start", 32'(frame_start), 32'(tbl[i].fs));
        end

        // Frame from vertical blanking, checking pixels against RAM contents
        for (int i = 0; i < 4 * WPL; i++) ram[i] = 16'($urandom);
        ram[0] = 16'h4321;
        run_line(524, 0, 799);
        pix_chk = 1'b1;
        step(0, 0);
        chk("first_addr", 32'(mem_addr), 32'd0);
        chk("first_we", 32'(mem_we), 32'd0);
        step(1, 0);
        chk("fs_h1", 32'(frame_start), 32'd0);
        for (int h = 2; h <= 5; h++) begin
            step(h, 0);
            chk("first_pixels", 32'(pixel), 32'(h - 1));
            chk("fs_pulse", 32'(frame_start), 32'(h == 2));
        end
        run_line(0, 6, 799);
        run_line(1, 0, 7);
        step(8, 1);
        chk("addr_v1_h8", 32'(mem_addr), 32'd162);
        chk("we_v1_h8", 32'(mem_we), 32'd0);
        run_line(1, 9, 640);
        step(641, 1);
        chk("von_641", 32'(video_on), 32'd1);
        step(642, 1);
        chk("von_642", 32'(video_on), 32'd0);
        run_line(1, 643, 799);
        run_line(2, 0, 656);
        step(657, 2); chk("hs_657", 32'(hsync), 32'd1);
        step(658, 2); chk("hs_658", 32'(hsync), 32'd0);
        run_line(2, 659, 752);
        step(753, 2); chk("hs_753", 32'(hsync), 32'd0);
        step(754, 2); chk("hs_754", 32'(hsync), 32'd1);
        run_line(2, 755, 799);
        run_line(3, 0, 799);
        for (int v = 489; v <= 492; v++) begin
            run_line(v, 0, 399);
            step(400, v);
            chk("vsync_line", 32'(vsync), 32'((v == 490 || v == 491) ? 0 : 1));
            run_line(v, 401, 799);
        end

        // Reset mid-frame with a write stuck behind a display slot
        pix_chk = 1'b0;
        wlog.delete();
        run_line(100, 0, 298);
        w.a = 17'h1ABCD; w.d = 16'hBEEF;
        wr_todo.push_back(w);
        step(299, 100);
        step(300, 100);
        chk("stall_before_rst", 32'(wr_ready), 32'd0);
        #5 RST = 1'b1;
        #1;
        chk("arst_pixel", 32'(pixel), 32'd0);
        chk("arst_hsync", 32'(hsync), 32'd1);
        chk("arst_vsync", 32'(vsync), 32'd1);
        chk("arst_video_on", 32'(video_on), 32'd0);
        chk("arst_frame_start", 32'(frame_start), 32'd0);
        chk("arst_we", 32'(mem_we), 32'd0);
        step(301, 100);
        step(302, 100);
        #5 RST = 1'b0;
        step(303, 100);
        chk("rel_ready", 32'(wr_ready), 32'd1);
        chk("rel_we", 32'(mem_we), 32'd0);
        chk("rel_pixel", 32'(pixel), 32'd0);
        run_line(100, 304, 799);
        chk("discarded_write", 32'(wlog.size()), 32'd0);

        // Single write offered on a display slot with an empty buffer
        wlog.delete(); alog.delete();
        w.a = 17'd5; w.d = 16'h5A5A;
        wr_todo.push_back(w);
        run_line(10, 0, 799);
        chk("w5_accepts", 32'(alog.size()), 32'd1);
        chk("w5_writes", 32'(wlog.size()), 32'd1);
        if (alog.size() > 0) chk("w5_accept_h", 32'(alog[0]), 32'd0);
        if (wlog.size() > 0) begin
            chk("w5_drain_h", 32'(wlog[0].h), 32'd1);
            chk("w5_drain_addr", 32'(wlog[0].a), 32'd5);
        end

        // Three back-to-back writes straddling a display slot
        wlog.delete(); alog.delete();
        run_line(11, 0, 2);
        for (int i = 0; i < 3; i++) begin
            w.a = 17'(80000 + i); w.d = 16'(16'hA000 + i);
            wr_todo.push_back(w);
        end
        step(3, 11);
        step(4, 11);
        chk("b2b_stall", 32'(wr_ready), 32'd0);
        run_line(11, 5, 799);
        chk("b2b_accepts", 32'(alog.size()), 32'd3);
        chk("b2b_writes", 32'(wlog.size()), 32'd3);
        cnt = (wlog.size() < 3) ? wlog.size() : 3;
        for (int i = 0; i < cnt; i++) begin
            chk("b2b_not_disp", 32'(wlog[i].h % 4 != 0), 32'd1);
            chk("b2b_h", 32'(wlog[i].h), 32'(5 + i));
            chk("b2b_order", 32'(wlog[i].a), 32'(80000 + i));
        end

        // Random writer traffic over active lines outside the displayed region
        for (int i = 0; i < 6 * WPL; i++) ram[i] = 16'($urandom);
        run_line(524, 0, 799);
        pix_chk = 1'b1;
        for (int v = 0; v < 6; v++) begin
            for (int h = 0; h < 800; h++) begin
                if ($urandom_range(0, 3) == 0 && wr_todo.size() < 2) begin
                    w.a = 17'(76800 + $urandom_range(0, 54271));
                    w.d = 16'($urandom);
                    wr_todo.push_back(w);
                end
                step(h, v);
            end
        end
        run_line(480, 0, 799);
        pix_chk = 1'b0;
        chk("drain_empty", 32'(sb.size() + wr_todo.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
